serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial adder that sits directly around the team's single-bit fullAdder cell. It feeds the cell one operand bit pair per clock, LSB first, and keeps the carry in a flip-flop between cycles. Sum bits are collected in a shift register. It is the area-minimal adder stage of the microprocessor datapath: it takes WIDTH-bit operands from the register file and hands one parallel result to the accumulator with a start/done handshake.

Parameters:
WIDTH, 4, operand and result width in bits (2..16).

Ports:
Clk    input   1      system clock; all state changes on its rising edge
Reset  input   1      synchronous, active-high reset
Start  input   1      request; operands sampled when accepted
A      input   WIDTH  operand A, sampled on accepted Start
B      input   WIDTH  operand B, sampled on accepted Start
Cin    input   1      carry-in, sampled on accepted Start
Busy   output  1      high while bit-serial addition is in progress
Done   output  1      one-cycle pulse when Sum/Cout/Ovf are updated
Sum    output  WIDTH  result register; held stable between completions
Cout   output  1      carry out of MSB; held with Sum
Ovf    output  1      two's-complement overflow (carry into MSB XOR Cout); held with Sum

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset, sampled at a rising edge, sets:
  - state = IDLE
  - Busy = 0, Done = 0
  - Sum = 0, Cout = 0, Ovf = 0
  - internal shift registers, carry flip-flop and bit counter = 0
- Reset has priority over every other input and aborts an operation in flight. Partial results are discarded, and Sum keeps 0 from the reset.
- States:
  - IDLE: Busy = 0, Done = 0.
  - SHIFT: Busy = 1, Done = 0.
  - DONE: Busy = 0, Done = 1.
- IDLE -> SHIFT on Start = 1. At that edge:
  - A, B are loaded into operand shift registers.
  - Cin is loaded into the carry flip-flop.
  - the counter is cleared.
- SHIFT, each edge:
  - s = a0 ^ b0 ^ c and c' = a0&b0 | c&(a0|b0), with the same function as the fullAdder cell.
  - s shifts into the MSB of the internal sum shift register, which shifts right.
  - the operand registers shift right by one, c <= c', counter increments.
  - on the edge where the counter = WIDTH-1 (the last bit):
    - the full result is copied to Sum, Cout <= c'.
    - Ovf <= c XOR c', where c is the carry into the MSB.
    - state -> DONE.
- DONE lasts exactly one cycle:
  - Start = 1 -> accepted, loads new operands, goes to SHIFT (back-to-back issue).
  - otherwise -> IDLE.
- Latency: Start accepted at edge k; Sum/Cout/Ovf update and Done rises at edge k+WIDTH; Done falls at edge k+WIDTH+1. Throughput is one add per WIDTH+1 cycles with back-to-back Start.
- Start while in SHIFT is ignored: no queueing, and operands are not resampled. A, B and Cin changing during SHIFT have no effect.
- Sum, Cout and Ovf change only at the completing edge or at reset. They never show partial values.
- Arithmetic: {Cout, Sum} = A + B + Cin, modulo 2^(WIDTH+1), with operands unsigned. Ovf interprets A, B and Sum as signed.
- Wrap-around: an all-ones operand plus Cin = 1 must give Sum = B and Cout = 1, with no special case.

Test Plan:
1. WIDTH=4. Reset for 2 cycles, then A=3, B=5, Cin=0, Start pulse.
   - Busy high for 4 cycles.
   - Done pulses at start edge +4.
   - Sum=8, Cout=0, Ovf=1.
2. A=15, B=1, Cin=0 -> Sum=0, Cout=1, Ovf=0.
   Then A=7, B=7, Cin=1 -> Sum=15, Cout=0, Ovf=1.
   Then A=15, B=15, Cin=1 -> Sum=15, Cout=1, Ovf=0.
3. Start A=2, B=2. Two cycles later, while Busy, pulse Start with A=9, B=9.
   - Second Start is ignored.
   - Sum=4 after a single Done.
   - No second Done follows.
4. Start A=6, B=3. Assert Reset at edge +2.
   - Next cycle: Busy=0, Done=0, Sum=0, Cout=0, Ovf=0.
   - No Done pulse afterwards.
5. Hold Start=1 continuously while changing A/B on each DONE cycle: (1,2), (4,4), (8,8).
   - Done pulses every 5 cycles.
   - Results in order: 3/0/0, 8/0/1, 0/1/1 (Sum/Cout/Ovf).
   - Sum stays stable between pulses.
6. Randomised: 500 operand/Cin triples, compared against the A+B+Cin reference model. Check that Sum never changes outside a Done edge.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, carry held in a flop.
// Result is published in parallel to Sum/Cout/Ovf only on the completing edge.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic [1:0]       State
);

    // Handshake: Start is accepted on any rising edge where the block is in
    // IDLE or DONE (Busy=0); Start while Busy is ignored. Done is a one-cycle
    // pulse marking the cycle in which Sum/Cout/Ovf first show a new result.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             carry_n;
    logic [WIDTH-1:0] sh_next;

    // Same function as the single-bit fullAdder cell.
    assign bit_s   = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_n = (a_q[0] & b_q[0]) | (c_q & (a_q[0] | b_q[0]));
    assign sh_next = {bit_s, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = Cin;
                    sh_d    = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry_n;
                sh_d  = sh_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // c_q here is the carry into the MSB, carry_n the carry out.
                    sum_d   = sh_next;
                    cout_d  = carry_n;
                    ovf_d   = c_q ^ carry_n;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Busy  = (state_q == SHIFT);
    assign Done  = (state_q == DONE);
    assign Sum   = sum_q;
    assign Cout  = cout_q;
    assign Ovf   = ovf_q;
    assign State = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=4: latency, handshake,
// reset abort, back-to-back issue and arithmetic against an A+B+Cin model.
module tb_serial_adder;

    localparam int W = 4;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic [1:0]   State;

    int n_cmp;
    int n_err;

    serial_adder #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf),
        .State (State)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sum may change only on a Done cycle or after a reset edge.
    logic         mon_en;
    logic         rst_last;
    logic [W-1:0] last_sum;

    always @(posedge Clk) rst_last = Reset;

    always @(negedge Clk) begin
        if (mon_en) begin
            n_cmp++;
            if (Sum !== last_sum && !Done && !rst_last) begin
                n_err++;
                $display("FAIL sum_stable: got %0h expected %0h at %0t", Sum, last_sum, $time);
            end
        end
        last_sum = Sum;
    end

    // Driver: issue one add, wait (bounded) for Done, report latency and busy cycles.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           output int lat, output int busy_cnt, output logic got);
        @(negedge Clk);
        Start = 1'b1;
        A     = a;
        B     = b;
        Cin   = cin;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A     = W'($urandom_range(0, 15));
        B     = W'($urandom_range(0, 15));
        Cin   = 1'($urandom_range(0, 1));
        lat      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (lat < 20 && !got) begin
            @(negedge Clk);
            lat++;
            if (Busy) busy_cnt++;
            if (Done) got = 1'b1;
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, busy_cnt, n, dones;
        logic got;
        logic [W:0] full;
        logic [W-1:0] ra, rb, es;
        logic rc, eo;
        logic [W-1:0] t5_a[3];
        logic [W-1:0] t5_b[3];
        logic [W-1:0] t5_s[3];
        logic t5_c[3];
        logic t5_o[3];

        vecs[0] = '{a: 4'd3,  b: 4'd5,  cin: 1'b0, sum: 4'd8,  cout: 1'b0, ovf: 1'b1};
        vecs[1] = '{a: 4'd15, b: 4'd1,  cin: 1'b0, sum: 4'd0,  cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 4'd7,  b: 4'd7,  cin: 1'b1, sum: 4'd15, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 4'd15, b: 4'd15, cin: 1'b1, sum: 4'd15, cout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, sum: 4'd0,  cout: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 4'd8,  b: 4'd8,  cin: 1'b0, sum: 4'd0,  cout: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 4'd15, b: 4'd9,  cin: 1'b1, sum: 4'd9,  cout: 1'b1, ovf: 1'b0};
        vecs[7] = '{a: 4'd5,  b: 4'd10, cin: 1'b0, sum: 4'd15, cout: 1'b0, ovf: 1'b0};

        t5_a = '{4'd1, 4'd4, 4'd8};
        t5_b = '{4'd2, 4'd4, 4'd8};
        t5_s = '{4'd3, 4'd8, 4'd0};
        t5_c = '{1'b0, 1'b0, 1'b1};
        t5_o = '{1'b0, 1'b1, 1'b1};

        n_cmp  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        Reset  = 1'b1;
        Start  = 1'b0;
        A      = '0;
        B      = '0;
        Cin    = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_sum",  Sum,  0);
        check("rst_cout", Cout, 0);
        check("rst_ovf",  Ovf,  0);
        mon_en = 1'b1;

        // Table-driven vectors, including latency and Busy width
        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, lat, busy_cnt, got);
            check("vec_done_seen", got, 1);
            check("vec_latency",   lat, W + 1);
            check("vec_busy_cyc",  busy_cnt, W);
            check("vec_sum",  Sum,  vecs[i].sum);
            check("vec_cout", Cout, vecs[i].cout);
            check("vec_ovf",  Ovf,  vecs[i].ovf);
            @(negedge Clk);
            check("vec_done_fall", Done, 0);
            check("vec_sum_hold",  Sum,  vecs[i].sum);
        end

        // Start while busy is ignored
        @(negedge Clk);
        Start = 1'b1; A = 4'd2; B = 4'd2; Cin = 1'b0;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Start = 1'b1; A = 4'd9; B = 4'd9;
        @(posedge Clk);
        #1 Start = 1'b0;
        n = 2;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge Clk);
            n++;
            if (Done) got = 1'b1;
        end
        check("ign_done_seen", got, 1);
        check("ign_latency", n, W + 1);
        check("ign_sum",  Sum,  4'd4);
        check("ign_cout", Cout, 0);
        check("ign_ovf",  Ovf,  0);
        dones = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        check("ign_no_2nd_done", dones, 0);

        // Reset aborts an operation in flight
        @(negedge Clk);
        Start = 1'b1; A = 4'd6; B = 4'd3; Cin = 1'b0;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_sum",  Sum,  0);
        check("abort_cout", Cout, 0);
        check("abort_ovf",  Ovf,  0);
        dones = 0;
        repeat (10) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        check("abort_no_done", dones, 0);

        // Back-to-back issue with Start held high
        @(negedge Clk);
        Start = 1'b1; A = t5_a[0]; B = t5_b[0]; Cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            got = 1'b0;
            while (n < 20 && !got) begin
                @(negedge Clk);
                n++;
                if (Done) got = 1'b1;
            end
            check("b2b_done_seen", got, 1);
            check("b2b_interval", n, W + 1);
            check("b2b_sum",  Sum,  t5_s[i]);
            check("b2b_cout", Cout, t5_c[i]);
            check("b2b_ovf",  Ovf,  t5_o[i]);
            if (i < 2) begin
                A = t5_a[i+1];
                B = t5_b[i+1];
            end else begin
                Start = 1'b0;
            end
        end
        @(negedge Clk);
        check("b2b_idle", State, 2'd0);

        // Randomised against the reference model
        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            es = full[W-1:0];
            eo = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
            run_add(ra, rb, rc, lat, busy_cnt, got);
            check("rnd_done_seen", got, 1);
            check("rnd_latency", lat, W + 1);
            check("rnd_sum",  Sum,  es);
            check("rnd_cout", Cout, full[W]);
            check("rnd_ovf",  Ovf,  eo);
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time bound in case a wait ever stalls
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
